// File: rtl/mmio_bus_responder_pkg.sv
// Shared definitions for the MMIO bus responder: the peripheral address map,
// the TCON bit positions, the address decode selector and the 7-seg decoder.
package mmio_pkg;

    localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
    localparam logic [31:0] ADDR_TH      = PERIPH_BASE + 32'h00;
    localparam logic [31:0] ADDR_TL      = PERIPH_BASE + 32'h04;
    localparam logic [31:0] ADDR_TCON    = PERIPH_BASE + 32'h08;
    localparam logic [31:0] ADDR_LED     = PERIPH_BASE + 32'h0C;
    localparam logic [31:0] ADDR_DIGITS  = PERIPH_BASE + 32'h10;
    localparam logic [31:0] ADDR_SYSTICK = PERIPH_BASE + 32'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // Display bus right after reset: digit 0 enabled, dp off, showing "0".
    localparam logic [11:0] BCD_RESET = 12'b1110_1_1000000;

    // Target of one bus access after address decode.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_DIGITS,
        SEL_SYSTICK
    } sel_t;

    // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mmio_bus_responder_seg7_scan.sv
// Four-digit multiplexed seven-segment driver. Each digit is lit for
// SCAN_DIV cycles in turn; the display bus is registered so it moves together
// with the digit index.
module seg7_scan
    import mmio_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    output logic [11:0] BCDout
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] prescaler;
    logic [1:0]    idx;
    logic          terminal;
    logic [1:0]    idx_next;
    logic [3:0]    nibble_next;

    // Work out where the scan will be after this edge so BCDout can follow it.
    always_comb begin
        terminal    = (prescaler == PW'(SCAN_DIV - 1));
        idx_next    = terminal ? idx + 2'd1 : idx;
        nibble_next = digits[{idx_next, 2'b00} +: 4];
    end

    // Prescaler, digit index and the registered anode/segment pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= 2'd0;
            BCDout    <= BCD_RESET;
        end else begin
            prescaler <= terminal ? '0 : prescaler + PW'(1);
            idx       <= idx_next;
            BCDout    <= {~(4'b0001 << idx_next), 1'b1, hex_to_seg(nibble_next)};
        end
    end

endmodule

// File: rtl/mmio_bus_responder.sv
// MEM-stage bus responder: decodes CPU loads/stores into data RAM or the
// peripheral block (reload timer, LEDs, display digits, cycle counter).
// Loads are answered combinationally; stores land on the clock edge.
module mmio_bus_responder
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int SCAN_DIV  = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    output logic        irq,
    output logic [11:0] BCDout
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic [31:0]   word_addr;
    sel_t          sel;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [15:0] digits;
    logic [31:0] systick;

    logic overflow;
    logic status_set;
    logic wr_th;
    logic wr_tl;
    logic wr_tcon;
    logic unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    // Address decode: low window goes to RAM, otherwise match a register.
    always_comb begin
        ram_idx   = addr[AW+1:2];
        word_addr = {addr[31:2], 2'b00};
        sel       = SEL_NONE;
        if (addr[31:AW+2] == '0) begin
            sel = SEL_RAM;
        end else begin
            case (word_addr)
                ADDR_TH:      sel = SEL_TH;
                ADDR_TL:      sel = SEL_TL;
                ADDR_TCON:    sel = SEL_TCON;
                ADDR_LED:     sel = SEL_LED;
                ADDR_DIGITS:  sel = SEL_DIGITS;
                ADDR_SYSTICK: sel = SEL_SYSTICK;
                default:      sel = SEL_NONE;
            endcase
        end
    end

    // Timer strobes; an overflow latches status only when irq is enabled.
    always_comb begin
        overflow   = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
        status_set = overflow && tcon[TCON_IE];
        wr_th      = mem_write && (sel == SEL_TH);
        wr_tl      = mem_write && (sel == SEL_TL);
        wr_tcon    = mem_write && (sel == SEL_TCON);
    end

    // Data RAM: cleared on reset, written by stores into the RAM window.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
                ram[i] <= '0;
            end
        end else if (mem_write && (sel == SEL_RAM)) begin
            ram[ram_idx] <= wdata;
        end
    end

    // Reload timer; CPU writes are applied last so they beat the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (tcon[TCON_EN]) begin
                tl <= overflow ? th : tl + 32'd1;
            end
            if (status_set) begin
                tcon[TCON_IS] <= 1'b1;
            end
            if (wr_th) begin
                th <= wdata;
            end
            if (wr_tl) begin
                tl <= wdata;
            end
            if (wr_tcon) begin
                tcon <= {wdata[TCON_IS] | status_set, wdata[TCON_IE], wdata[TCON_EN]};
            end
        end
    end

    // LED and display-digit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            led    <= '0;
            digits <= '0;
        end else if (mem_write) begin
            if (sel == SEL_LED) begin
                led <= wdata[7:0];
            end
            if (sel == SEL_DIGITS) begin
                digits <= wdata[15:0];
            end
        end
    end

    // Free-running cycle counter; not writable from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    assign irq = tcon[TCON_IE] & tcon[TCON_IS];

    // Load data mux; zero when no load is requested or nothing is mapped.
    always_comb begin
        rdata = '0;
        if (mem_read) begin
            case (sel)
                SEL_RAM:     rdata = ram[ram_idx];
                SEL_TH:      rdata = th;
                SEL_TL:      rdata = tl;
                SEL_TCON:    rdata = {29'd0, tcon};
                SEL_LED:     rdata = {24'd0, led};
                SEL_DIGITS:  rdata = {16'd0, digits};
                SEL_SYSTICK: rdata = systick;
                default:     rdata = '0;
            endcase
        end
    end

    seg7_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .digits(digits),
        .BCDout(BCDout)
    );

endmodule
